// File: rtl/mux_pkg.sv
// ----------------------------------------------------------------------------
// mux_pkg
//   Shared definitions for the N:1 stream multiplexer slice.
//   - MODE_FIXED / MODE_RR : encodings of the 'mode' input.
//   - clog2_safe(n)        : index width for an n-entry set, never below 1 bit,
//                            so a 2-input (or degenerate) mux still gets a
//                            usable select/pointer port.
// ----------------------------------------------------------------------------
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Combinational rotate-priority encoder. Starting at position 'ptr' and
//   scanning upward with wrap-around, the first asserted request wins.
//   The pointer itself lives in the instantiating module.
//
//   Ports:
//     req      in   N    request vector
//     ptr      in   IW   highest-priority position (expected < N)
//     gnt      out  N    one-hot grant, zero when no request
//     gnt_idx  out  IW   index of the granted request (0 when none)
//     any_gnt  out  1    some request was granted
// ----------------------------------------------------------------------------
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2_safe(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any_gnt
);

    always_comb begin
        int c;
        c       = 0;
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        // Walk N positions beginning at ptr; the modulo keeps the scan inside
        // the channel set even when N is not a power of two.
        for (int k = 0; k < N; k++) begin
            c = (int'(ptr) + k) % N;
            if (!any_gnt && req[c]) begin
                any_gnt = 1'b1;
                gnt[c]  = 1'b1;
                gnt_idx = IW'(c);
            end
        end
    end

endmodule

// File: rtl/mux_nx1_stream.sv
// ----------------------------------------------------------------------------
// mux_nx1_stream
//   N_IN-input, WIDTH-bit stream multiplexer with one registered output stage
//   and valid/ready handshakes on every port. Channel choice is either the
//   explicit 'sel' (fixed mode) or a round-robin scan over valid inputs.
//
//   Ports:
//     clk        in   1           rising-edge clock
//     rst_n      in   1           asynchronous active-low reset
//     mode       in   1           0 = fixed select, 1 = round-robin
//     sel        in   SEL_W       channel index used in fixed mode
//     in_valid   in   N_IN        per-channel valid
//     in_data    in   N_IN*WIDTH  channel i at [i*WIDTH +: WIDTH]
//     in_ready   out  N_IN        per-channel ready (combinational, <=1 hot)
//     out_valid  out  1           output register holds a word
//     out_data   out  WIDTH       registered data
//     out_ch     out  SEL_W       channel that produced out_data
//     out_ready  in   1           consumer accepts the word
//     sel_err    out  1           registered flag: fixed-mode sel out of range
//                                 while the output stage could have loaded
// ----------------------------------------------------------------------------
module mux_nx1_stream
    import mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_IN  = 4,
    parameter int SEL_W = clog2_safe(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_IN-1:0]       in_valid,
    input  logic [N_IN*WIDTH-1:0] in_data,
    output logic [N_IN-1:0]       in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    input  logic                  out_ready,
    output logic                  sel_err
);

    // One extra bit so N_IN itself is representable when N_IN == 2**SEL_W.
    localparam logic [SEL_W:0]   N_LIM = (SEL_W+1)'(N_IN);
    localparam logic [SEL_W-1:0] LAST  = SEL_W'(N_IN - 1);

    logic [SEL_W-1:0] rr_ptr;
    logic             load_en;
    logic             sel_ok;
    logic [N_IN-1:0]  fixed_gnt;
    logic [N_IN-1:0]  rr_gnt;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_any;
    logic [N_IN-1:0]  gnt;
    logic [SEL_W-1:0] gnt_idx;
    logic             xfer;
    logic [WIDTH-1:0] mux_data;

    // The register can take a word when empty or when its current word is
    // leaving this same cycle (no bubble on back-to-back traffic).
    assign load_en = !out_valid || out_ready;

    // ------------------------------------------------------------------
    // Fixed-select grant. An out-of-range sel grants nothing; the compare
    // is done before any indexing so in_valid is never read out of bounds.
    // ------------------------------------------------------------------
    assign sel_ok = {1'b0, sel} < N_LIM;

    always_comb begin
        fixed_gnt = '0;
        for (int i = 0; i < N_IN; i++)
            fixed_gnt[i] = sel_ok && (sel == SEL_W'(i)) && in_valid[i];
    end

    // ------------------------------------------------------------------
    // Round-robin grant
    // ------------------------------------------------------------------
    rr_arbiter #(
        .N  (N_IN),
        .IW (SEL_W)
    ) u_rr (
        .req     (in_valid),
        .ptr     (rr_ptr),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx),
        .any_gnt (rr_any)
    );

    // Mode is applied combinationally, so a switch takes effect this cycle.
    assign gnt      = (mode == MODE_RR) ? rr_gnt : fixed_gnt;
    assign gnt_idx  = (mode == MODE_RR) ? rr_idx : sel;
    assign in_ready = load_en ? gnt : '0;
    assign xfer     = load_en && ((mode == MODE_RR) ? rr_any : |fixed_gnt);

    // One-hot AND-OR data select; zero when nothing is granted.
    always_comb begin
        mux_data = '0;
        for (int i = 0; i < N_IN; i++)
            if (gnt[i])
                mux_data |= in_data[i*WIDTH +: WIDTH];
    end

    // ------------------------------------------------------------------
    // Output register. Data/channel only change on a transfer so the last
    // word stays visible after the stage drains.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= mux_data;
            out_ch    <= gnt_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Round-robin pointer: moves just past the winner, only on an RR
    // transfer; held in fixed mode so the rotation resumes where it left.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_ptr <= '0;
        else if (mode == MODE_RR && xfer)
            rr_ptr <= (rr_idx == LAST) ? '0 : rr_idx + 1'b1;
    end

    // ------------------------------------------------------------------
    // Select error: raised only when a load was actually possible, so a
    // stalled output stage does not report a stale bad select.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sel_err <= 1'b0;
        else
            sel_err <= (mode == MODE_FIXED) && !sel_ok && load_en;
    end

endmodule

// File: tb/tb_mux_nx1_stream.sv
module tb_mux_nx1_stream;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 4-input instance
    logic        mode = 1'b0;
    logic [1:0]  sel = '0;
    logic [3:0]  iv = '0;
    logic [31:0] idata = '0;
    logic [3:0]  irdy;
    logic        ov;
    logic [7:0]  od;
    logic [1:0]  och;
    logic        ordy = 1'b0;
    logic        serr;

    // 3-input instance (out-of-range select, non power-of-two wrap)
    logic        mode3 = 1'b0;
    logic [1:0]  sel3 = '0;
    logic [2:0]  iv3 = '0;
    logic [23:0] idata3 = '0;
    logic [2:0]  irdy3;
    logic        ov3;
    logic [7:0]  od3;
    logic [1:0]  och3;
    logic        ordy3 = 1'b0;
    logic        serr3;

    mux_nx1_stream #(.WIDTH(8), .N_IN(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_valid(iv), .in_data(idata), .in_ready(irdy),
        .out_valid(ov), .out_data(od), .out_ch(och),
        .out_ready(ordy), .sel_err(serr)
    );

    mux_nx1_stream #(.WIDTH(8), .N_IN(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
        .in_valid(iv3), .in_data(idata3), .in_ready(irdy3),
        .out_valid(ov3), .out_data(od3), .out_ch(och3),
        .out_ready(ordy3), .sel_err(serr3)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model (4 channels) ----------------
    localparam int N = 4;
    logic       m_ov;
    logic [7:0] m_od;
    int         m_ch;
    int         m_ptr;
    logic       m_err;
    logic [3:0] last_rdy;

    task automatic model_reset();
        m_ov = 0; m_od = 0; m_ch = 0; m_ptr = 0; m_err = 0;
    endtask

    // One clock: drive inputs on the falling edge, check the ready vector,
    // then let the edge happen and check the registered outputs.
    task automatic cycle(input logic m, input logic [1:0] s, input logic [3:0] v,
                         input logic r, input logic [31:0] d);
        bit  load;
        int  g;
        logic [3:0] e_rdy;
        @(negedge clk);
        mode = m; sel = s; iv = v; ordy = r; idata = d;
        #1;
        load = !m_ov || r;
        g = -1;
        if (m == 1'b0) begin
            if (int'(s) < N && v[s]) g = int'(s);
        end else begin
            for (int k = 0; k < N; k++)
                if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
        e_rdy = (load && g >= 0) ? 4'(1 << g) : 4'b0;
        last_rdy = irdy;
        chk("in_ready", {28'b0, irdy}, {28'b0, e_rdy});
        @(posedge clk);
        m_err = (m == 1'b0) && (int'(s) >= N) && load;
        if (e_rdy != 0) begin
            m_ov = 1; m_od = d[g*8 +: 8]; m_ch = g;
            if (m) m_ptr = (g + 1) % N;
        end else if (r) begin
            m_ov = 0;
        end
        #1;
        chk("out_valid", {31'b0, ov}, {31'b0, m_ov});
        chk("out_data", {24'b0, od}, {24'b0, m_od});
        chk("out_ch", {30'b0, och}, 32'(m_ch));
        chk("sel_err", {31'b0, serr}, {31'b0, m_err});
    endtask

    // ---------------- directed vector table (4 channels) ----------------
    typedef struct {
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  iv;
        logic        ordy;
        logic [31:0] data;
        logic [3:0]  e_rdy;
        logic        e_ov;
        logic [7:0]  e_od;
        logic [1:0]  e_ch;
    } vec_t;

    function automatic vec_t mk(input logic m, input logic [1:0] s, input logic [3:0] v,
                                input logic r, input logic [31:0] d, input logic [3:0] er,
                                input logic eo, input logic [7:0] ed, input logic [1:0] ec);
        vec_t t;
        t.mode = m; t.sel = s; t.iv = v; t.ordy = r; t.data = d;
        t.e_rdy = er; t.e_ov = eo; t.e_od = ed; t.e_ch = ec;
        return t;
    endfunction

    vec_t tbl[19];

    initial begin
        // fixed select ch2
        tbl[0]  = mk(0, 2, 4'b0100, 1, 32'h13A51110, 4'b0100, 1, 8'hA5, 2);
        // round-robin, all valid
        tbl[1]  = mk(1, 0, 4'b1111, 1, 32'h13121110, 4'b0001, 1, 8'h10, 0);
        tbl[2]  = mk(1, 0, 4'b1111, 1, 32'h13121110, 4'b0010, 1, 8'h11, 1);
        tbl[3]  = mk(1, 0, 4'b1111, 1, 32'h13121110, 4'b0100, 1, 8'h12, 2);
        tbl[4]  = mk(1, 0, 4'b1111, 1, 32'h13121110, 4'b1000, 1, 8'h13, 3);
        tbl[5]  = mk(1, 0, 4'b1111, 1, 32'h13121110, 4'b0001, 1, 8'h10, 0);
        // round-robin with gaps from pointer 1
        tbl[6]  = mk(1, 0, 4'b1001, 1, 32'h13121110, 4'b1000, 1, 8'h13, 3);
        tbl[7]  = mk(1, 0, 4'b1001, 1, 32'h13121110, 4'b0001, 1, 8'h10, 0);
        tbl[8]  = mk(1, 0, 4'b1001, 1, 32'h13121110, 4'b1000, 1, 8'h13, 3);
        // back-pressure then drain+load with no bubble
        tbl[9]  = mk(0, 1, 4'b0010, 1, 32'h13124210, 4'b0010, 1, 8'h42, 1);
        tbl[10] = mk(0, 1, 4'b0010, 0, 32'h13127710, 4'b0000, 1, 8'h42, 1);
        tbl[11] = mk(0, 1, 4'b0010, 0, 32'h13127710, 4'b0000, 1, 8'h42, 1);
        tbl[12] = mk(0, 1, 4'b0010, 0, 32'h13127710, 4'b0000, 1, 8'h42, 1);
        tbl[13] = mk(0, 1, 4'b0010, 1, 32'h13127710, 4'b0010, 1, 8'h77, 1);
        // drain, idle, and selected channel not valid
        tbl[14] = mk(0, 1, 4'b0000, 1, 32'h13127710, 4'b0000, 0, 8'h77, 1);
        tbl[15] = mk(0, 1, 4'b0000, 0, 32'h13127710, 4'b0000, 0, 8'h77, 1);
        tbl[16] = mk(0, 1, 4'b0100, 1, 32'h13127710, 4'b0000, 0, 8'h77, 1);
        // back to round-robin: pointer preserved at 0 across fixed mode
        tbl[17] = mk(1, 0, 4'b0110, 1, 32'h13127710, 4'b0010, 1, 8'h77, 1);
        tbl[18] = mk(1, 0, 4'b0110, 1, 32'h13127710, 4'b0100, 1, 8'h12, 2);

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst out_valid", {31'b0, ov}, 32'd0);
        chk("rst out_data", {24'b0, od}, 32'd0);
        chk("rst out_ch", {30'b0, och}, 32'd0);
        chk("rst sel_err", {31'b0, serr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            cycle(tbl[i].mode, tbl[i].sel, tbl[i].iv, tbl[i].ordy, tbl[i].data);
            chk($sformatf("tbl%0d in_ready", i), {28'b0, last_rdy}, {28'b0, tbl[i].e_rdy});
            chk($sformatf("tbl%0d out_valid", i), {31'b0, ov}, {31'b0, tbl[i].e_ov});
            chk($sformatf("tbl%0d out_data", i), {24'b0, od}, {24'b0, tbl[i].e_od});
            chk($sformatf("tbl%0d out_ch", i), {30'b0, och}, {30'b0, tbl[i].e_ch});
        end

        // randomized traffic against the model
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) != 0), $urandom);

        // asynchronous reset with a word held in the output register
        cycle(0, 1, 4'b0010, 1, 32'h13125510);
        cycle(0, 1, 4'b0000, 0, 32'h13125510);
        chk("pre-rst out_valid", {31'b0, ov}, 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst out_valid", {31'b0, ov}, 32'd0);
        chk("async rst out_data", {24'b0, od}, 32'd0);
        chk("async rst out_ch", {30'b0, och}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        // pointer back at 0 after reset
        cycle(1, 0, 4'b1111, 1, 32'h44332211);
        chk("post-rst rr ch", {30'b0, och}, 32'd0);

        // ---------------- 3-input instance ----------------
        @(negedge clk);
        mode3 = 0; sel3 = 3; iv3 = 3'b111; ordy3 = 1; idata3 = 24'h332211;
        #1 chk("n3 bad sel in_ready", {29'b0, irdy3}, 32'd0);
        @(posedge clk); #1;
        chk("n3 sel_err pulse", {31'b0, serr3}, 32'd1);
        chk("n3 bad sel out_valid", {31'b0, ov3}, 32'd0);
        @(negedge clk);
        sel3 = 0; iv3 = 3'b000;
        @(posedge clk); #1;
        chk("n3 sel_err clear", {31'b0, serr3}, 32'd0);
        @(negedge clk);
        sel3 = 2; iv3 = 3'b100;
        #1 chk("n3 sel2 in_ready", {29'b0, irdy3}, 32'b100);
        @(posedge clk); #1;
        chk("n3 sel2 out_data", {24'b0, od3}, 32'h33);
        chk("n3 sel2 out_ch", {30'b0, och3}, 32'd2);
        @(negedge clk);
        sel3 = 3; ordy3 = 0;
        @(posedge clk); #1;
        chk("n3 stalled sel_err", {31'b0, serr3}, 32'd0);
        chk("n3 stalled out_valid", {31'b0, ov3}, 32'd1);
        @(negedge clk);
        ordy3 = 1;
        @(posedge clk); #1;
        chk("n3 drain sel_err", {31'b0, serr3}, 32'd1);
        chk("n3 drain out_valid", {31'b0, ov3}, 32'd0);
        // round-robin wrap with three channels; sel ignored
        @(negedge clk);
        mode3 = 1; iv3 = 3'b111;
        @(posedge clk); #1;
        chk("n3 rr ch0", {30'b0, och3}, 32'd0);
        chk("n3 rr sel_err", {31'b0, serr3}, 32'd0);
        @(negedge clk);
        iv3 = 3'b100;
        @(posedge clk); #1;
        chk("n3 rr ch2", {30'b0, och3}, 32'd2);
        chk("n3 rr data", {24'b0, od3}, 32'h33);
        @(negedge clk);
        iv3 = 3'b111;
        @(posedge clk); #1;
        chk("n3 rr wrap ch0", {30'b0, och3}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_nx1_stream.md
Name: mux_nx1_stream

Overview:
Parametrised N-input, WIDTH-bit multiplexer with a registered output stage and a valid/ready handshake on every port. It generalises the team's 2:1 combinational mux family in three ways:
- arbitrary channel count and data width;
- a selectable round-robin mode in addition to explicit select;
- back-pressure handling.

It sits between several producer streams and a single consumer, such as a shared bus or FIFO write port.

Parameters:
- WIDTH, 8, data width per channel in bits.
- N_IN, 4, number of input channels (>=2).
- SEL_W, $clog2(N_IN), select/channel-index width (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = fixed select (sel), 1 = round-robin over valid inputs.
- sel  input  SEL_W  channel index used in fixed mode.
- in_valid  input  N_IN  per-channel valid.
- in_data  input  N_IN*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N_IN  per-channel ready (combinational).
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered data.
- out_ch  output  SEL_W  index of the channel that produced out_data.
- out_ready  input  1  consumer accepts the word.
- sel_err  output  1  one-cycle pulse: fixed-mode sel >= N_IN while load is possible.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_ch=0, sel_err=0, rr_ptr=0. All take effect immediately with no clock.
- load_en = !out_valid || out_ready. The register may load when it is empty or being drained in the same cycle.
- Fixed mode (mode=0):
  - Grant channel sel iff sel < N_IN and in_valid[sel] and load_en.
  - sel >= N_IN: no grant, no transfer. sel_err=1 on the next cycle if load_en, 0 otherwise.
- Round-robin mode (mode=1):
  - Grant the first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... N_IN-1, 0, ... (wrap-around), provided load_en.
  - On a granted transfer, rr_ptr <= (grant+1) mod N_IN.
  - rr_ptr is held when there is no transfer and while mode=0.
  - sel is ignored and sel_err stays 0.
- in_ready[i] = load_en && grant[i]. At most one bit is set, and it is zero when no grant.
- A transfer on channel i occurs when in_valid[i] && in_ready[i]. On the next edge:
  - out_data <= in_data[i];
  - out_ch <= i;
  - out_valid <= 1.
- No grant and out_ready=1: out_valid <= 0. out_data and out_ch hold their last values.
- Back-pressure: while out_valid && !out_ready, out_data, out_ch and out_valid are held and all in_ready=0.
- Latency: 1 cycle from input handshake to out_valid. Throughput is 1 word/cycle when out_ready is held high.
- Simultaneous drain and load (out_valid=1, out_ready=1, grant present): the new word replaces the old one with no bubble.
- Mode change: takes effect in the same cycle, combinationally. rr_ptr is preserved across mode switches.
- Reset mid-transfer: any in-flight output word is discarded. There is no partial state.
- Inputs are assumed synchronous to clk. No internal synchronisers.

Decomposition:
- Shared package mux_pkg:
  - MODE_FIXED = 1'b0, MODE_RR = 1'b1;
  - function clog2_safe returning 1 for N_IN <= 2.
- One sub-module: rr_arbiter (parameter N), a combinational rotate-priority encoder.
  - Inputs: req[N], ptr.
  - Outputs: gnt[N] one-hot, gnt_idx, any_gnt.
- The top module holds:
  - the fixed/RR grant select;
  - the output register;
  - rr_ptr;
  - sel_err.

Test Plan (WIDTH=8, N_IN=4):
1. Reset: hold rst_n=0 mid-simulation with out_valid=1 -> out_valid=0, out_data=0x00, out_ch=0 immediately, before the next edge.
2. Fixed mode: mode=0, sel=2, in_valid=4'b0100, ch2=0xA5, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=0xA5, out_ch=2.
3. Fixed mode, out-of-range select: drive sel=3 with N_IN=3 (separate instance), in_valid=3'b111 -> in_ready=0, sel_err pulses 1 for one cycle, out_valid=0.
4. Round-robin: mode=1, in_valid=4'b1111 continuous, out_ready=1, data ch_i=0x10+i -> out_ch sequence 0,1,2,3,0 and out_data 0x10,0x11,0x12,0x13,0x10.
5. Round-robin with gaps: in_valid=4'b1001 starting from rr_ptr=1 -> grants ch3, then ch0, then ch3.
6. Back-pressure: out_ready=0 for 3 cycles with out_valid=1, out_data=0x42 -> data held at 0x42, in_ready=0. Raise out_ready with ch1 valid (0x77) -> next cycle out_data=0x77 with no bubble cycle.
